// File: rtl/logic_unit_scheduler.sv
// logic_unit_scheduler
// Shares one registered AND/OR logic unit among N_REQ requesters. A request is arbitrated
// and its operands are latched. The unit's CE is pulsed for a single cycle. The unit's Q is
// then returned to the winning requester with a valid/ack handshake. At most one operation
// is in flight at a time.
// Build option: define LU_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins, no
// round-robin pointer). Leave it undefined for the default round-robin arbitration.
module logic_unit_scheduler #(
  parameter int N_REQ = 4,
  parameter int DW    = 1,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  CLK,
  input  logic                  Clr,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   op_a,
  input  logic [N_REQ*DW-1:0]   op_b,
  input  logic [N_REQ-1:0]      op_c,
  output logic [N_REQ-1:0]      gnt,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_data,
  input  logic                  rsp_ack,
  output logic                  busy,
  output logic [DW-1:0]         lu_a,
  output logic [DW-1:0]         lu_b,
  output logic                  lu_c,
  output logic                  lu_ce,
  input  logic [DW-1:0]         lu_q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic               busy_q;
  logic [DW-1:0]      lu_a_q;
  logic [DW-1:0]      lu_b_q;
  logic               lu_c_q;
  logic               lu_ce_q;

  logic               win_found_s;
  logic [IDW-1:0]     win_idx_s;
  logic [IDW-1:0]     cand_s;
  logic [N_REQ-1:0]   win_onehot_s;
  logic [DW-1:0]      sel_a_s;
  logic [DW-1:0]      sel_b_s;
  logic               sel_c_s;

`ifndef LU_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_d;
`endif

  // Pick the winner: first active requester at or after the pointer, or the lowest index in fixed mode.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef LU_SCHED_FIXED_PRIO_EN
      cand_s = IDW'(k);
`else
      cand_s = IDW'((int'(ptr_q) + k) % N_REQ);
`endif
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
        win_idx_s   = win_idx_s;
      end
    end
  end

  // Extract the winner's operand slices and build its one-hot grant vector.
  always_comb begin
    sel_a_s      = op_a[win_idx_s*DW +: DW];
    sel_b_s      = op_b[win_idx_s*DW +: DW];
    sel_c_s      = op_c[win_idx_s];
    win_onehot_s = N_REQ'(1) << win_idx_s;
  end

`ifndef LU_SCHED_FIXED_PRIO_EN
  // Compute the pointer value that follows the current winner, wrapping after the last requester.
  always_comb begin
    if (win_idx_s == IDW'(N_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx_s + IDW'(1);
    end
  end
`endif

  // Sequence each operation IDLE -> ISSUE -> RESP, and drive all outputs from registers.
  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_c_q      <= 1'b0;
      lu_ce_q     <= 1'b0;
`ifndef LU_SCHED_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found_s) begin
            state_q  <= ST_ISSUE;
            gnt_q    <= win_onehot_s;
            rsp_id_q <= win_idx_s;
            lu_a_q   <= sel_a_s;
            lu_b_q   <= sel_b_s;
            lu_c_q   <= sel_c_s;
            lu_ce_q  <= 1'b1;
            busy_q   <= 1'b1;
`ifndef LU_SCHED_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
          end else begin
            gnt_q   <= '0;
            lu_ce_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // The unit captures the operands on this edge, so Q is valid from RESP onward.
          state_q     <= ST_RESP;
          gnt_q       <= '0;
          lu_ce_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ack) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          gnt_q       <= '0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          lu_ce_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_c      = lu_c_q;
  assign lu_ce     = lu_ce_q;
  // Because CE is idle during RESP, Q is stable there and can be forwarded without another register stage.
  assign rsp_data  = rsp_valid_q ? lu_q : '0;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Testbench for logic_unit_scheduler. It contains a behavioural model of the shared AND/OR unit,
// a table of per-cycle vectors, and hand-written multi-cycle sequences.
module tb_logic_unit_scheduler;
  localparam int N_REQ = 4;
  localparam int DW    = 1;
  localparam int IDW   = 2;

  logic             CLK = 1'b0;
  logic             Clr = 1'b1;
  logic [3:0]       req = 4'b0000;
  logic [3:0]       op_a = 4'b0000;
  logic [3:0]       op_b = 4'b0000;
  logic [3:0]       op_c = 4'b0000;
  logic [3:0]       gnt;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [0:0]       rsp_data;
  logic             rsp_ack = 1'b0;
  logic             busy;
  logic [0:0]       lu_a;
  logic [0:0]       lu_b;
  logic             lu_c;
  logic             lu_ce;
  logic [0:0]       lu_q;

  int n_chk  = 0;
  int n_fail = 0;

  logic_unit_scheduler #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW)) dut (
    .CLK(CLK), .Clr(Clr), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ack(rsp_ack), .busy(busy), .lu_a(lu_a), .lu_b(lu_b), .lu_c(lu_c),
    .lu_ce(lu_ce), .lu_q(lu_q)
  );

  always #5 CLK = ~CLK;

  // Behavioural model of the shared unit: registered, cleared by Clr, and it captures when CE is high.
  always @(posedge CLK or posedge Clr) begin
    if (Clr) lu_q <= 1'b0;
    else if (lu_ce) lu_q <= lu_c ? (lu_a | lu_b) : (lu_a & lu_b);
  end

  typedef struct {
    logic       clr;
    logic [3:0] rq, a, b, c;
    logic       ack;
    logic [3:0] e_gnt;
    logic       e_ce, e_v;
    logic [1:0] e_id;
    logic       e_d, e_busy;
    logic [2:0] e_lu;   // {lu_a, lu_b, lu_c}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic clr, logic [3:0] rq, logic [3:0] a, logic [3:0] b,
                              logic [3:0] c, logic ack, logic [3:0] e_gnt, logic e_ce,
                              logic e_v, logic [1:0] e_id, logic e_d, logic e_busy,
                              logic [2:0] e_lu);
    vec_t v;
    v.clr = clr; v.rq = rq; v.a = a; v.b = b; v.c = c; v.ack = ack;
    v.e_gnt = e_gnt; v.e_ce = e_ce; v.e_v = e_v; v.e_id = e_id; v.e_d = e_d;
    v.e_busy = e_busy; v.e_lu = e_lu;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    // Test 1: a single OR operation by requester 0, acknowledged, then idle.
    vq.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000));
    vq.push_back(mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 3'b101));
    vq.push_back(mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 3'b101));
    vq.push_back(mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b101));
    vq.push_back(mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b101));
    vq.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000));
`ifndef LU_SCHED_FIXED_PRIO_EN
    // Test 2: all four requesters held, ack always high; expected grant order is 0,1,2,3,0.
    // Per requester (a,b,c): r0=(1,1,AND)->1, r1=(0,1,AND)->0, r2=(1,0,OR)->1, r3=(0,0,OR)->0.
    for (int k = 0; k < 5; k++) begin
      logic [1:0] id;
      logic [2:0] lu;
      logic       d;
      id = 2'(k % 4);
      case (id)
        2'd0: begin lu = 3'b110; d = 1'b1; end
        2'd1: begin lu = 3'b010; d = 1'b0; end
        2'd2: begin lu = 3'b101; d = 1'b1; end
        default: begin lu = 3'b001; d = 1'b0; end
      endcase
      vq.push_back(mk(1'b0, 4'hF, 4'h5, 4'h3, 4'hC, 1'b1, 4'(4'h1 << id), 1'b1, 1'b0, id, 1'b0, 1'b1, lu));
      vq.push_back(mk(1'b0, 4'hF, 4'h5, 4'h3, 4'hC, 1'b1, 4'h0, 1'b0, 1'b1, id, d, 1'b1, lu));
      vq.push_back(mk(1'b0, 4'hF, 4'h5, 4'h3, 4'hC, 1'b1, 4'h0, 1'b0, 1'b0, id, 1'b0, 1'b0, lu));
    end
`else
    // Test 6: requesters 1 and 3 held; fixed priority grants requester 1 every time.
    for (int k = 0; k < 3; k++) begin
      vq.push_back(mk(1'b0, 4'hA, 4'h5, 4'h3, 4'hC, 1'b1, 4'h2, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 3'b010));
      vq.push_back(mk(1'b0, 4'hA, 4'h5, 4'h3, 4'hC, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 3'b010));
      vq.push_back(mk(1'b0, 4'hA, 4'h5, 4'h3, 4'hC, 1'b1, 4'h0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b010));
    end
`endif

    @(negedge CLK);
    foreach (vq[i]) begin
      Clr = vq[i].clr; req = vq[i].rq; op_a = vq[i].a; op_b = vq[i].b;
      op_c = vq[i].c; rsp_ack = vq[i].ack;
      step();
      chk($sformatf("row%0d gnt", i),       32'(gnt),       32'(vq[i].e_gnt));
      chk($sformatf("row%0d lu_ce", i),     32'(lu_ce),     32'(vq[i].e_ce));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(vq[i].e_v));
      chk($sformatf("row%0d rsp_id", i),    32'(rsp_id),    32'(vq[i].e_id));
      chk($sformatf("row%0d rsp_data", i),  32'(rsp_data),  32'(vq[i].e_d));
      chk($sformatf("row%0d busy", i),      32'(busy),      32'(vq[i].e_busy));
      chk($sformatf("row%0d lu_abc", i),    32'({lu_a, lu_b, lu_c}), 32'(vq[i].e_lu));
    end
    Clr = 1'b0; req = 4'h0; rsp_ack = 1'b0;

    // Test 3: result held stable while ack is withheld; an operand change after grant is ignored.
    Clr = 1'b1; step(); Clr = 1'b0;
    req = 4'h1; op_a = 4'h1; op_b = 4'h1; op_c = 4'h0;
    step();
    chk("t3 gnt", 32'(gnt), 32'h1);
    op_a = 4'h0; req = 4'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t3 hold%0d valid", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("t3 hold%0d data", k),  32'(rsp_data),  32'h1);
    end
    rsp_ack = 1'b1;
    step();
    chk("t3 after ack valid", 32'(rsp_valid), 32'h0);
    chk("t3 after ack busy",  32'(busy),      32'h0);
    rsp_ack = 1'b0;

    // Test 4: Clr during ISSUE aborts the operation and resets the pointer.
    // At this point the pointer is 1, so requester 1 wins and the pointer moves to 2.
    req = 4'h2; op_a = 4'h2; op_b = 4'h2; op_c = 4'h0;
    step();
    chk("t4 gnt", 32'(gnt), 32'h2);
    chk("t4 ce",  32'(lu_ce), 32'h1);
    Clr = 1'b1; req = 4'h0;
    #1;
    chk("t4 clr gnt",   32'(gnt),   32'h0);
    chk("t4 clr ce",    32'(lu_ce), 32'h0);
    chk("t4 clr busy",  32'(busy),  32'h0);
    chk("t4 clr valid", 32'(rsp_valid), 32'h0);
    chk("t4 clr lu",    32'({lu_a, lu_b, lu_c}), 32'h0);
    chk("t4 clr id",    32'(rsp_id), 32'h0);
    @(posedge CLK); @(negedge CLK);
    Clr = 1'b0;
    chk("t4 no rsp a", 32'(rsp_valid), 32'h0);
    step();
    chk("t4 no rsp b", 32'(rsp_valid), 32'h0);
    chk("t4 idle busy", 32'(busy), 32'h0);
    // Requesters 0 and 2 are both active. Requester 0 wins only if the pointer was reset to 0.
    req = 4'h5; op_a = 4'h5; op_b = 4'h5; op_c = 4'h0;
    step();
    chk("t4 ptr reset gnt", 32'(gnt), 32'h1);
    req = 4'h4;
    step();
    chk("t4 r0 valid", 32'(rsp_valid), 32'h1);
    chk("t4 r0 id",    32'(rsp_id),    32'h0);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    step();
    chk("t4 r2 gnt", 32'(gnt), 32'h4);
    req = 4'h0;
    step();
    chk("t4 r2 valid", 32'(rsp_valid), 32'h1);
    chk("t4 r2 id",    32'(rsp_id),    32'h2);
    chk("t4 r2 data",  32'(rsp_data),  32'h1);
    rsp_ack = 1'b1;
    step();
    chk("t4 r2 done", 32'(busy), 32'h0);

    // Test 5: ack held high while idle has no effect; the response still appears for one cycle.
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5 idle%0d valid", k), 32'(rsp_valid), 32'h0);
    end
    req = 4'h2; op_a = 4'h0; op_b = 4'h2; op_c = 4'h2;
    step();
    chk("t5 gnt", 32'(gnt), 32'h2);
    req = 4'h0;
    step();
    chk("t5 valid", 32'(rsp_valid), 32'h1);
    chk("t5 id",    32'(rsp_id),    32'h1);
    chk("t5 data",  32'(rsp_data),  32'h1);
    step();
    chk("t5 done valid", 32'(rsp_valid), 32'h0);
    chk("t5 done data",  32'(rsp_data),  32'h0);
    rsp_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
